fifo_drain_dma: RTL and testbench

Downstream consumer of the 16-entry transfer FIFO in the ALU-DMAC datapath. Once programmed with a destination address and a word count, it pops words from the FIFO one at a time and writes each to the system bus through a request/grant master port. The destination address increments by 4 bytes per word. The block signals completion with a done pulse.

---
 rtl/fifo_drain_dma_pkg.sv | 18 +
 rtl/fifo_drain_dma_addr_cnt.sv | 51 +++++
 rtl/fifo_drain_dma.sv | 176 +++++++++++++++++
 tb/tb_fifo_drain_dma.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_dma_pkg.sv
// Shared types and default widths for the FIFO-drain DMA write master.
package dma_pkg;

  localparam int unsigned DMA_ADDR_W  = 32;
  localparam int unsigned DMA_DATA_W  = 32;
  localparam int unsigned DMA_LEN_W   = 16;
  localparam int unsigned ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REQ   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/fifo_drain_dma_addr_cnt.sv
// Destination address and remaining-word counter for the drain DMA.
module dma_addr_cnt
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W,
  parameter int unsigned LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  // Next address/count: load on accepted start, advance one word per write.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = addr_in;
      rem_d  = len_in;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(ADDR_STRIDE);
      rem_d  = rem_q - LEN_W'(1);
    end else begin
      addr_d = addr_q;
      rem_d  = rem_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= {ADDR_W{1'b0}};
      rem_q  <= {LEN_W{1'b0}};
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == LEN_W'(1));

endmodule

// File: rtl/fifo_drain_dma.sv
// Pops words from the transfer FIFO and writes them to consecutive bus addresses.
// Optional completion interrupt (irq/irq_clr) is built when FIFO_DRAIN_IRQ_EN is defined.
module fifo_drain_dma
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W,
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_rd_ack,
  input  logic              fifo_rd_err,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata
`ifdef FIFO_DRAIN_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);

  dma_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              cnt_load, cnt_step, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;

  dma_addr_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .step    (cnt_step),
    .addr_in (dst_addr),
    .len_in  (length),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );

  // Next-state and output decode from the registered state.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    fifo_rd_en = 1'b0;
    m_req      = 1'b0;
    m_wr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (length != {LEN_W{1'b0}}) begin
            cnt_load = 1'b1;
            state_d  = ST_POP;
          end else begin
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_rd_ack) begin
          data_d  = fifo_dout;
          state_d = ST_REQ;
        end else if (fifo_rd_err) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_REQ: begin
        m_req = 1'b1;
        // Bus outputs are registered so they hold their value outside WRITE.
        if (m_grant) begin
          m_addr_d  = cnt_addr;
          m_wdata_d = data_q;
          state_d   = ST_WRITE;
        end else begin
          state_d   = ST_REQ;
        end
      end
      ST_WRITE: begin
        m_req    = 1'b1;
        m_wr     = 1'b1;
        cnt_step = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_POP;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured FIFO word and bus output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= {DATA_W{1'b0}};
      m_addr_q  <= {ADDR_W{1'b0}};
      m_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

`ifdef FIFO_DRAIN_IRQ_EN
  logic irq_q, irq_d;

  // Sticky completion flag; a DONE cycle overrides a simultaneous clear.
  always_comb begin
    if (state_q == ST_DONE) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q | (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_fifo_drain_dma.sv
// Directed bench for fifo_drain_dma with a behavioural 1-cycle-latency FIFO.
module tb_fifo_drain_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] length = 16'h0;
  logic        busy, done, fifo_rd_en;
  logic [31:0] fifo_dout = 32'h0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_ack = 1'b0;
  logic        fifo_rd_err = 1'b0;
  logic        m_req, m_wr;
  logic        m_grant = 1'b1;
  logic [31:0] m_addr, m_wdata;
`ifdef FIFO_DRAIN_IRQ_EN
  logic        irq_clr = 1'b0;
  logic        irq;
`endif

  fifo_drain_dma dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dst_addr    (dst_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_ack (fifo_rd_ack),
    .fifo_rd_err (fifo_rd_err),
    .m_req       (m_req),
    .m_grant     (m_grant),
    .m_wr        (m_wr),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata)
`ifdef FIFO_DRAIN_IRQ_EN
    ,
    .irq_clr     (irq_clr),
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          k0 = 0;
  int          g = 0;
  logic [31:0] fq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          done_cnt, done_cyc, rd_seen, req_cnt;
  logic        rd_pre;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; done_cyc = -1; rd_seen = 0; req_cnt = 0;
  endtask

  task automatic push(input logic [31:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Sample outputs mid-cycle, then advance one clock and update the FIFO model.
  task automatic tick();
    @(negedge clk);
    if (m_wr) begin wa.push_back(m_addr); wd.push_back(m_wdata); wc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (fifo_rd_en) rd_seen++;
    if (m_req) req_cnt++;
    rd_pre = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    fifo_rd_ack = 1'b0;
    fifo_rd_err = 1'b0;
    if (rd_pre) begin
      if (fq.size() > 0) begin
        fifo_dout = fq.pop_front();
        fifo_rd_ack = 1'b1;
      end else begin
        fifo_rd_err = 1'b1;
      end
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic kick(input logic [31:0] a, input logic [15:0] n);
    dst_addr = a; length = n; start = 1'b1;
    k0 = cyc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_busy", {31'h0, busy}, 32'h0);
    check_vec("rst_ctl", {27'h0, done, fifo_rd_en, m_req, m_wr, 1'b0}, 32'h0);
    check_vec("rst_addr", m_addr, 32'h0);
    check_vec("rst_wdata", m_wdata, 32'h0);
    reset = 1'b0;

    // Basic three-word transfer, grant always high.
    push(32'h1000_0000); push(32'h2000_0000); push(32'h3000_0000);
    clear_log();
    kick(32'h100, 16'd3);
    repeat (19) tick();
    check_vec("basic_nwr", wa.size(), 32'd3);
    if (wa.size() == 3) begin
      check_vec("basic_a0", wa[0], 32'h100);
      check_vec("basic_d0", wd[0], 32'h1000_0000);
      check_vec("basic_a1", wa[1], 32'h104);
      check_vec("basic_d1", wd[1], 32'h2000_0000);
      check_vec("basic_a2", wa[2], 32'h108);
      check_vec("basic_d2", wd[2], 32'h3000_0000);
      check_vec("basic_t0", wc[0] - k0, 32'd4);
      check_vec("basic_gap1", wc[1] - wc[0], 32'd4);
      check_vec("basic_gap2", wc[2] - wc[1], 32'd4);
    end
    check_vec("basic_done_n", done_cnt, 32'd1);
    check_vec("basic_done_t", done_cyc - k0, 32'd13);
    check_vec("basic_busy", {31'h0, busy}, 32'h0);

    // Empty FIFO stall, two words arriving late.
    clear_log();
    kick(32'h200, 16'd2);
    repeat (9) tick();
    check_vec("stall_rden", rd_seen, 32'd0);
    check_vec("stall_req", req_cnt, 32'd0);
    push(32'h4000_0000);
    repeat (10) tick();
    check_vec("stall_nwr1", wa.size(), 32'd1);
    if (wa.size() >= 1) begin
      check_vec("stall_a0", wa[0], 32'h200);
      check_vec("stall_d0", wd[0], 32'h4000_0000);
    end
    check_vec("stall_busy", {31'h0, busy}, 32'h1);
    check_vec("stall_nodone", done_cnt, 32'd0);
    push(32'h5000_0000);
    repeat (10) tick();
    check_vec("stall_nwr2", wa.size(), 32'd2);
    if (wa.size() == 2) check_vec("stall_a1", wa[1], 32'h204);
    check_vec("stall_done", done_cnt, 32'd1);

    // Grant held low for five REQ cycles.
    m_grant = 1'b0;
    push(32'h6000_0000);
    kick(32'h300, 16'd1);
    tick(); tick();
    clear_log();
    repeat (5) tick();
    check_vec("gnt_req", req_cnt, 32'd5);
    check_vec("gnt_nowr", wa.size(), 32'd0);
    m_grant = 1'b1;
    g = cyc;
    repeat (5) tick();
    check_vec("gnt_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      check_vec("gnt_t", wc[0] - g, 32'd1);
      check_vec("gnt_d", wd[0], 32'h6000_0000);
      check_vec("gnt_a", wa[0], 32'h300);
    end

    // Zero length: immediate done, no FIFO or bus traffic.
    push(32'hDEAD_BEEF);
    clear_log();
    kick(32'h800, 16'd0);
    repeat (4) tick();
    check_vec("zero_done_t", done_cyc - k0, 32'd1);
    check_vec("zero_done_n", done_cnt, 32'd1);
    check_vec("zero_rden", rd_seen, 32'd0);
    check_vec("zero_nwr", wa.size(), 32'd0);
    fq.delete(); fifo_empty = 1'b1;

    // Start pulse mid-transfer is ignored.
    push(32'hA000_0000); push(32'hB000_0000);
    clear_log();
    kick(32'h400, 16'd2);
    tick(); tick();
    dst_addr = 32'h900; length = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check_vec("ign_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      check_vec("ign_a1", wa[1], 32'h404);
      check_vec("ign_d1", wd[1], 32'hB000_0000);
    end
    check_vec("ign_done", done_cnt, 32'd1);

    // Reset asserted during REQ of word 2 of 4.
    push(32'h1); push(32'h2); push(32'h3); push(32'h4);
    clear_log();
    kick(32'h500, 16'd4);
    repeat (4) tick();
    m_grant = 1'b0;
    tick(); tick();
    check_vec("rmid_inreq", {31'h0, m_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_vec("rmid_busy", {31'h0, busy}, 32'h0);
    check_vec("rmid_ctl", {27'h0, done, fifo_rd_en, m_req, m_wr, 1'b0}, 32'h0);
    check_vec("rmid_addr", m_addr, 32'h0);
    check_vec("rmid_wdata", m_wdata, 32'h0);
`ifdef FIFO_DRAIN_IRQ_EN
    check_vec("rmid_irq", {31'h0, irq}, 32'h0);
`endif
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    check_vec("rmid_nodone", done_cnt, 32'd0);
    fq.delete(); fifo_empty = 1'b1; fifo_rd_ack = 1'b0;
    m_grant = 1'b1;
    push(32'h7000_0000);
    clear_log();
    kick(32'h600, 16'd1);
    repeat (8) tick();
    check_vec("rnew_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      check_vec("rnew_a", wa[0], 32'h600);
      check_vec("rnew_d", wd[0], 32'h7000_0000);
    end
    check_vec("rnew_done", done_cnt, 32'd1);

`ifdef FIFO_DRAIN_IRQ_EN
    // Sticky interrupt, then clear coinciding with DONE.
    check_vec("irq_hold", {31'h0, irq}, 32'h1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_vec("irq_clr", {31'h0, irq}, 32'h0);
    push(32'h8000_0000);
    kick(32'h700, 16'd1);
    repeat (4) tick();
    check_vec("irq_rise", {30'h0, done, irq}, 32'h3);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_vec("irq_setwins", {31'h0, irq}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
